// File: rtl/droid_pkg.sv
// Shared definitions for the battle-droid command processor.
//   - opcode encodings accepted on the command interface
//   - FSM state encoding (also the value driven on the 'state' output)
//   - battery selection codes and the rank reset value
//   - op_defined(): 1 for any opcode that has a defined meaning
package droid_pkg;

  localparam logic [3:0] OP_NOOP     = 4'b0000;
  localparam logic [3:0] OP_STANDBY  = 4'b0100;
  localparam logic [3:0] OP_ATTACK   = 4'b0101;
  localparam logic [3:0] OP_GOTO     = 4'b0110;
  localparam logic [3:0] OP_TARGET   = 4'b0111;
  localparam logic [3:0] OP_RANK     = 4'b1000;
  localparam logic [3:0] OP_BATTERY  = 4'b1001;
  localparam logic [3:0] OP_ATLOC    = 4'b1010;
  localparam logic [3:0] OP_RESET    = 4'b1100;
  localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

  typedef enum logic [1:0] {
    ST_SHUTDOWN = 2'b00,
    ST_STANDBY  = 2'b01,
    ST_GOTO     = 2'b10,
    ST_ATTACK   = 2'b11
  } droid_state_e;

  localparam logic [1:0] BATT_LONG   = 2'b01;
  localparam logic [1:0] BATT_IDLE   = 2'b10;
  localparam logic [1:0] BATT_COMBAT = 2'b11;

  localparam int RANK_RESET = 1;

  function automatic logic op_defined(input logic [3:0] op);
    logic ok;
    case (op)
      OP_NOOP, OP_STANDBY, OP_ATTACK, OP_GOTO, OP_TARGET,
      OP_RANK, OP_BATTERY, OP_ATLOC, OP_RESET, OP_SHUTDOWN: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/droid_goto_timer.sv
// GOTO phase supervisor: counts cycles spent in GOTO, compares the live GPS
// position with the destination, and raises one-cycle arrived/timeout pulses.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_goto      controller is currently in the GOTO state
//   halt         emergency stop (suppresses pulses, clears the timer)
//   gps          live position
//   cur_loc      GOTO destination
//   end_goto     combinational: GOTO finishes at the coming clock edge
//   arrived      registered pulse: GOTO ended because gps==cur_loc
//   timeout      registered pulse: GOTO ended because the timer expired
module droid_goto_timer #(
  parameter int LOC_W    = 16,
  parameter int GOTO_TMO = 255,
  parameter int TMO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_goto,
  input  logic             halt,
  input  logic [LOC_W-1:0] gps,
  input  logic [LOC_W-1:0] cur_loc,
  output logic             end_goto,
  output logic             arrived,
  output logic             timeout
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GOTO_TMO - 1);

  logic [TMO_W-1:0] timer;
  logic             active;
  logic             match;
  logic             expire;

  assign active   = in_goto & ~halt;
  assign match    = (gps == cur_loc);
  assign expire   = (timer == TMO_LAST);
  assign end_goto = active & (match | expire);

  // The timer is held at zero whenever the droid is not travelling, so every
  // GOTO starts counting from zero without a separate start strobe. Arrival
  // wins over expiry so the two pulses can never fire together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      arrived <= 1'b0;
      timeout <= 1'b0;
    end else begin
      arrived <= active & match;
      timeout <= active & ~match & expire;
      if (active && !end_goto) timer <= timer + 1'b1;
      else                     timer <= '0;
    end
  end

endmodule

// File: rtl/droid_controller.sv
// Registered command processor for one battle droid.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (see below)
//   opcode, data_in,   command opcode and operands
//   loc_in
//   gps                live GPS position
//   halt               emergency stop (level, highest priority)
//   state              current FSM state (00 SHUTDOWN 01 STANDBY 10 GOTO 11 ATTACK)
//   cur_loc            GOTO destination
//   target_loc         attack target
//   rank               saturating rank accumulator
//   batt               battery selection
//   at_loc             last ATLOC result
//   arrived, timeout   one-cycle GOTO completion pulses
//   bad_op             one-cycle pulse on an accepted undefined opcode
//   data_out           registered result of the last command that took effect
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; its effects are visible one cycle later. cmd_ready is
// low while travelling (GOTO) or while halt is asserted. The source may change
// or drop cmd_valid freely when cmd_ready is low; nothing is captured then.
module droid_controller
  import droid_pkg::*;
#(
  parameter int LOC_W    = 16,
  parameter int DATA_W   = 8,
  parameter int RANK_W   = 8,
  parameter int GOTO_TMO = 255,
  parameter int TMO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LOC_W-1:0]  loc_in,
  input  logic [LOC_W-1:0]  gps,
  input  logic              halt,
  output logic [1:0]        state,
  output logic [LOC_W-1:0]  cur_loc,
  output logic [LOC_W-1:0]  target_loc,
  output logic [RANK_W-1:0] rank,
  output logic [1:0]        batt,
  output logic              at_loc,
  output logic              arrived,
  output logic              timeout,
  output logic              bad_op,
  output logic [DATA_W-1:0] data_out
);

  droid_state_e      state_q, state_d;
  logic [LOC_W-1:0]  cur_loc_d, target_loc_d;
  logic [RANK_W-1:0] rank_d, rank_sat;
  logic [RANK_W:0]   rank_sum;
  logic [1:0]        batt_d;
  logic              at_loc_d, at_cmp;
  logic              bad_op_d;
  logic [DATA_W-1:0] data_out_d;
  logic              accept;
  logic              ignored;
  logic              end_goto;

  assign cmd_ready = (state_q != ST_GOTO) & ~halt;
  assign accept    = cmd_valid & cmd_ready;
  assign state     = state_q;

  // While shut down the droid only listens for RESET and STANDBY; anything
  // else is consumed by the handshake but leaves every register untouched.
  assign ignored = (state_q == ST_SHUTDOWN) && (opcode != OP_RESET) && (opcode != OP_STANDBY);

  assign rank_sum = {1'b0, rank} + {1'b0, data_in[RANK_W-1:0]};
  assign rank_sat = rank_sum[RANK_W] ? {RANK_W{1'b1}} : rank_sum[RANK_W-1:0];

  // A zero location operand means "am I at my GOTO destination?".
  assign at_cmp = (loc_in == '0) ? (cur_loc == gps) : (loc_in == gps);

  droid_goto_timer #(
    .LOC_W    (LOC_W),
    .GOTO_TMO (GOTO_TMO),
    .TMO_W    (TMO_W)
  ) u_goto_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_goto  (state_q == ST_GOTO),
    .halt     (halt),
    .gps      (gps),
    .cur_loc  (cur_loc),
    .end_goto (end_goto),
    .arrived  (arrived),
    .timeout  (timeout)
  );

  always_comb begin
    state_d      = state_q;
    cur_loc_d    = cur_loc;
    target_loc_d = target_loc;
    rank_d       = rank;
    batt_d       = batt;
    at_loc_d     = at_loc;
    bad_op_d     = 1'b0;
    data_out_d   = data_out;

    if (halt) begin
      state_d = ST_SHUTDOWN;
      batt_d  = BATT_IDLE;
    end else if (state_q == ST_GOTO) begin
      if (end_goto) state_d = ST_STANDBY;
    end else if (accept) begin
      bad_op_d = ~op_defined(opcode);
      if (!ignored) begin
        data_out_d = DATA_W'(opcode);
        case (opcode)
          OP_STANDBY: begin
            state_d = ST_STANDBY;
            batt_d  = BATT_LONG;
          end
          OP_ATTACK: begin
            state_d = ST_ATTACK;
            batt_d  = BATT_COMBAT;
          end
          OP_GOTO: begin
            cur_loc_d = loc_in;
            state_d   = ST_GOTO;
            batt_d    = BATT_LONG;
          end
          OP_TARGET:  target_loc_d = loc_in;
          OP_RANK: begin
            rank_d     = rank_sat;
            data_out_d = DATA_W'(rank_sat);
          end
          OP_BATTERY: if (data_in[1:0] != 2'b00) batt_d = data_in[1:0];
          OP_ATLOC: begin
            at_loc_d   = at_cmp;
            data_out_d = DATA_W'(at_cmp);
          end
          OP_RESET: begin
            state_d      = ST_SHUTDOWN;
            cur_loc_d    = '0;
            target_loc_d = '0;
            rank_d       = RANK_W'(RANK_RESET);
            batt_d       = BATT_IDLE;
            at_loc_d     = 1'b0;
            data_out_d   = '0;
          end
          OP_SHUTDOWN: begin
            state_d = ST_SHUTDOWN;
            batt_d  = BATT_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SHUTDOWN;
      cur_loc    <= '0;
      target_loc <= '0;
      rank       <= RANK_W'(RANK_RESET);
      batt       <= BATT_IDLE;
      at_loc     <= 1'b0;
      bad_op     <= 1'b0;
      data_out   <= '0;
    end else begin
      state_q    <= state_d;
      cur_loc    <= cur_loc_d;
      target_loc <= target_loc_d;
      rank       <= rank_d;
      batt       <= batt_d;
      at_loc     <= at_loc_d;
      bad_op     <= bad_op_d;
      data_out   <= data_out_d;
    end
  end

endmodule
